// File: rtl/pb_pkg.sv
// Shared constants for the pushbutton front-end: default sizing and the
// button-index map used by the calculator decoders.
package pb_pkg;

    localparam int NUM_PB_DEFAULT        = 10;
    localparam int DEBOUNCE_DEFAULT      = 50000;
    localparam int REPEAT_DELAY_DEFAULT  = 500000;
    localparam int REPEAT_PERIOD_DEFAULT = 100000;

    localparam int PB_KEY0 = 0;
    localparam int PB_KEY1 = 1;
    localparam int PB_WEN  = 2;
    localparam int PB_REN  = 3;
    localparam int PB_OP0  = 4;
    localparam int PB_OP1  = 5;
    localparam int PB_REG0 = 6;
    localparam int PB_REG1 = 7;
    localparam int PB_REG2 = 8;
    localparam int PB_REG3 = 9;

    function automatic int pb_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pb_debounce_cell.sv
// Single-button conditioner: 2-flop synchronizer, counter debounce, press one-shot.
// Optional hold-to-repeat pulses when PB_REPEAT_EN is defined.
module pb_debounce_cell
    import pb_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
    input  logic clk,
    input  logic nrst,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          mismatch;
    logic          accept;
    logic          rep_fire;

    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign mismatch = (sync2 != level);
    assign accept   = mismatch && (cnt == CNT_LAST);

    // Any sample agreeing with the current level restarts the stability count.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            if (!mismatch || accept) cnt <= '0;
            else                     cnt <= cnt + 1'b1;
            if (accept) level <= sync2;
        end
    end

`ifdef PB_REPEAT_EN
    localparam int HW = $clog2(pb_max(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    logic [HW-1:0] hold;
    logic [HW-1:0] hold_last;
    logic          rep_phase;

    // NOTE: combinational blocks assign every output first so no latch is inferred.
    always_comb begin
        hold_last = HW'(REPEAT_DELAY - 1);
        if (rep_phase) hold_last = HW'(REPEAT_PERIOD - 1);
    end

    // No repeat on the cycle a release is accepted.
    assign rep_fire = level && !accept && (hold == hold_last);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hold      <= '0;
            rep_phase <= 1'b0;
        end else if (!level || accept) begin
            hold      <= '0;
            rep_phase <= 1'b0;
        end else if (rep_fire) begin
            hold      <= '0;
            rep_phase <= 1'b1;
        end else begin
            hold <= hold + 1'b1;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) pulse <= 1'b0;
        else       pulse <= (accept && sync2) || rep_fire;
    end

endmodule

// File: rtl/pb_conditioner.sv
// Pushbutton front-end for the calculator: one debounce cell per button plus
// an activity OR. Define PB_REPEAT_EN to enable hold-to-repeat pulses.
module pb_conditioner
    import pb_pkg::*;
#(
    parameter int NUM_PB          = NUM_PB_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [NUM_PB-1:0] pb_raw,
    output logic [NUM_PB-1:0] pb_level,
    output logic [NUM_PB-1:0] pb_pulse,
    output logic              pb_any
);

    for (genvar i = 0; i < NUM_PB; i++) begin : g_cell
        pb_debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_cell (
            .clk   (clk),
            .nrst  (nrst),
            .raw   (pb_raw[i]),
            .level (pb_level[i]),
            .pulse (pb_pulse[i])
        );
    end

    assign pb_any = |pb_level;

endmodule

// File: tb/tb_pb_conditioner.sv
// Self-checking bench for pb_conditioner: directed scenarios plus random
// button activity compared cycle by cycle against a rule-level model.
module tb_pb_conditioner;
    import pb_pkg::*;

    localparam int NPB = 10;
    localparam int DB  = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;

    logic           clk = 1'b0;
    logic           nrst = 1'b0;
    logic [NPB-1:0] pb_raw = '0;
    logic [NPB-1:0] pb_level;
    logic [NPB-1:0] pb_pulse;
    logic           pb_any;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: raw delayed two cycles, accepted level, run lengths.
    logic [NPB-1:0] m_s1, m_s2, m_level, m_pulse;
    int             m_run  [NPB];
    int             m_held [NPB];

    pb_conditioner #(
        .NUM_PB          (NPB),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .pb_raw   (pb_raw),
        .pb_level (pb_level),
        .pb_pulse (pb_pulse),
        .pb_any   (pb_any)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, summary not yet printed");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        m_s1 = '0; m_s2 = '0; m_level = '0; m_pulse = '0;
        for (int i = 0; i < NPB; i++) begin
            m_run[i]  = 0;
            m_held[i] = 0;
        end
    endtask

    // A level flips once the synchronized input has disagreed with it for DB
    // consecutive samples; a press yields one pulse, holding may add repeats.
    task automatic model_edge();
        logic lvl_old, lvl_new, p;
        if (!nrst) begin
            model_clear();
            return;
        end
        for (int i = 0; i < NPB; i++) begin
            lvl_old = m_level[i];
            lvl_new = lvl_old;
            p       = 1'b0;
            if (m_s2[i] != lvl_old) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    lvl_new  = m_s2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
            if (lvl_new && !lvl_old) begin
                p         = 1'b1;
                m_held[i] = 0;
            end else if (lvl_new) begin
                m_held[i]++;
`ifdef PB_REPEAT_EN
                if (m_held[i] == RD || (m_held[i] > RD && (m_held[i] - RD) % RP == 0)) p = 1'b1;
`endif
            end else begin
                m_held[i] = 0;
            end
            m_level[i] = lvl_new;
            m_pulse[i] = p;
        end
        m_s2 = m_s1;
        m_s1 = pb_raw;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic settle(input int n);
        repeat (n) step();
    endtask

    task automatic test_reset();
        nrst   = 1'b0;
        pb_raw = NPB'($urandom);
        model_clear();
        for (int c = 0; c < 3; c++) begin
            step();
            vectors++;
            if ({pb_level, pb_pulse, pb_any} !== {(2*NPB+1){1'b0}}) begin
                miscompares++;
                $display("FAIL reset_state c=%0d level=%h pulse=%h any=%b required all 0",
                         c, pb_level, pb_pulse, pb_any);
            end
        end
        pb_raw = '0;
        nrst   = 1'b1;
        settle(3);
    endtask

    task automatic test_clean_press();
        pb_raw[PB_KEY0] = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            step();
            if (c == 7) pb_raw[PB_KEY0] = 1'b0;
            vectors++;
            if (pb_pulse[PB_KEY0] !== (c == 6) || pb_level[PB_KEY0] !== (c >= 6 && c < 13)) begin
                miscompares++;
                $display("FAIL clean_press c=%0d level=%b pulse=%b required level=%b pulse=%b",
                         c, pb_level[PB_KEY0], pb_pulse[PB_KEY0], (c >= 6 && c < 13), (c == 6));
            end
            vectors++;
            if (pb_level !== m_level || pb_pulse !== m_pulse || pb_any !== |m_level) begin
                miscompares++;
                $display("FAIL clean_model c=%0d level=%h/%h pulse=%h/%h (got/required)",
                         c, pb_level, m_level, pb_pulse, m_pulse);
            end
        end
        settle(6);
    endtask

    task automatic test_bounce();
        logic [4:0] press   = 5'b10101;
        logic [4:0] release_b = 5'b01010;
        int pulses = 0;
        for (int c = 0; c < 4; c++) begin
            pb_raw[PB_REN] = press[c];
            step();
            pulses += int'(pb_pulse[PB_REN]);
        end
        pb_raw[PB_REN] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            pulses += int'(pb_pulse[PB_REN]);
            vectors++;
            if (pb_pulse[PB_REN] !== (k == 6)) begin
                miscompares++;
                $display("FAIL bounce_press k=%0d pulse=%b required %b", k, pb_pulse[PB_REN], (k == 6));
            end
        end
        for (int c = 0; c < 18; c++) begin
            pb_raw[PB_REN] = (c < 5) ? release_b[c] : 1'b0;
            step();
            pulses += int'(pb_pulse[PB_REN]);
            vectors++;
            if (pb_pulse !== m_pulse || pb_level !== m_level || pb_pulse[PB_REN] !== 1'b0) begin
                miscompares++;
                $display("FAIL bounce_release c=%0d pulse=%h/%h level=%h/%h (got/required)",
                         c, pb_pulse, m_pulse, pb_level, m_level);
            end
        end
        vectors++;
        if (pulses != 1 || pb_level[PB_REN] !== 1'b0) begin
            miscompares++;
            $display("FAIL bounce_count pulses=%0d level=%b required 1 pulse, level 0",
                     pulses, pb_level[PB_REN]);
        end
    endtask

    task automatic test_glitch();
        for (int c = 0; c < 14; c++) begin
            pb_raw[PB_OP1] = (c < 3);
            step();
            vectors++;
            if (pb_level[PB_OP1] !== 1'b0 || pb_pulse[PB_OP1] !== 1'b0 || pb_pulse !== m_pulse) begin
                miscompares++;
                $display("FAIL short_glitch c=%0d level=%b pulse=%b required 0 0",
                         c, pb_level[PB_OP1], pb_pulse[PB_OP1]);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [NPB-1:0] regs = '0;
        regs[PB_REG0] = 1'b1; regs[PB_REG1] = 1'b1;
        regs[PB_REG2] = 1'b1; regs[PB_REG3] = 1'b1;
        pb_raw = regs;
        for (int k = 1; k <= 8; k++) begin
            step();
            vectors++;
            if (pb_pulse !== ((k == 6) ? 10'h3C0 : 10'h000) || pb_any !== (k >= 6)) begin
                miscompares++;
                $display("FAIL simultaneous k=%0d pulse=%h any=%b required pulse=%h any=%b",
                         k, pb_pulse, pb_any, (k == 6) ? 10'h3C0 : 10'h000, (k >= 6));
            end
        end
        pb_raw = '0;
        settle(10);
    endtask

    task automatic test_reset_mid();
        pb_raw[PB_WEN] = 1'b1;
        settle(4);
        nrst = 1'b0;
        model_clear();
        #1;
        vectors++;
        if ({pb_level, pb_pulse, pb_any} !== {(2*NPB+1){1'b0}}) begin
            miscompares++;
            $display("FAIL reset_async level=%h pulse=%h any=%b required all 0", pb_level, pb_pulse, pb_any);
        end
        step();
        vectors++;
        if ({pb_level, pb_pulse, pb_any} !== {(2*NPB+1){1'b0}}) begin
            miscompares++;
            $display("FAIL reset_hold level=%h pulse=%h any=%b required all 0", pb_level, pb_pulse, pb_any);
        end
        nrst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            vectors++;
            if (pb_pulse[PB_WEN] !== (k == 6) || pb_pulse !== m_pulse) begin
                miscompares++;
                $display("FAIL reset_mid k=%0d pulse=%h required bit2=%b model=%h",
                         k, pb_pulse, (k == 6), m_pulse);
            end
        end
        pb_raw[PB_WEN] = 1'b0;
        settle(10);
    endtask

    task automatic test_repeat();
        int pulses = 0;
`ifdef PB_REPEAT_EN
        // Held 30 samples: release accepted at cycle 36, pulses 6,16,19,...,34.
        int exp_pulses = 8;
`else
        int exp_pulses = 1;
`endif
        pb_raw[PB_KEY1] = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            step();
            if (c == 30) pb_raw[PB_KEY1] = 1'b0;
            pulses += int'(pb_pulse[PB_KEY1]);
            vectors++;
            if (pb_pulse !== m_pulse || pb_level !== m_level) begin
                miscompares++;
                $display("FAIL repeat_model c=%0d pulse=%h/%h level=%h/%h (got/required)",
                         c, pb_pulse, m_pulse, pb_level, m_level);
            end
        end
        vectors++;
        if (pulses != exp_pulses) begin
            miscompares++;
            $display("FAIL repeat_count pulses=%0d required %0d", pulses, exp_pulses);
        end
    endtask

    task automatic test_random();
        int left [NPB];
        for (int i = 0; i < NPB; i++) left[i] = $urandom_range(1, 12);
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                nrst = 1'b0;
                model_clear();
                #1;
                vectors++;
                if ({pb_level, pb_pulse, pb_any} !== {(2*NPB+1){1'b0}}) begin
                    miscompares++;
                    $display("FAIL random_reset c=%0d level=%h pulse=%h required 0", c, pb_level, pb_pulse);
                end
                step();
                nrst = 1'b1;
            end
            for (int i = 0; i < NPB; i++) begin
                left[i]--;
                if (left[i] <= 0) begin
                    pb_raw[i] = ~pb_raw[i];
                    left[i]   = $urandom_range(1, 12);
                end
            end
            step();
            vectors++;
            if (pb_level !== m_level || pb_pulse !== m_pulse || pb_any !== |m_level) begin
                miscompares++;
                $display("FAIL random c=%0d raw=%h level=%h/%h pulse=%h/%h (got/required)",
                         c, pb_raw, pb_level, m_level, pb_pulse, m_pulse);
            end
        end
        pb_raw = '0;
        settle(12);
    endtask

    initial begin
        model_clear();
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_repeat();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
